// File: rtl/mem_defs_pkg.sv
// Shared definitions for the RAM MOV/MOC initiator: SPARC load/store op3
// codes, RAM size encodings, FSM state encoding and the alignment rule.
package mem_defs_pkg;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2,
        S_FIN     = 2'd3
    } mem_state_t;

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_HALF: return a[0];
            SZ_WORD: return |a;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Combinational op3 decoder: maps a SPARC load/store opcode onto the RAM's
// size/sign/rw inputs and flags anything that is not a load or store.
module mem_op_decode
    import mem_defs_pkg::*;
(
    input  logic [5:0] op3,
    output logic [1:0] size,
    output logic       sign,
    output logic       rw,
    output logic       illegal
);

    // Table lookup; unknown opcodes fall through to the illegal default.
    always_comb begin
        size    = SZ_BYTE;
        sign    = 1'b0;
        rw      = 1'b1;
        illegal = 1'b0;
        case (op3)
            OP_LDSB: begin size = SZ_BYTE; sign = 1'b1; end
            OP_LDSH: begin size = SZ_HALF; sign = 1'b1; end
            OP_LDUB: size = SZ_BYTE;
            OP_LDUH: size = SZ_HALF;
            OP_LD:   size = SZ_WORD;
            OP_STB:  begin size = SZ_BYTE; rw = 1'b0; end
            OP_STH:  begin size = SZ_HALF; rw = 1'b0; end
            OP_ST:   begin size = SZ_WORD; rw = 1'b0; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the RAM MOV/MOC handshake. Takes one load/store from the
// control unit, checks it, runs the handshake and reports with a done pulse.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for req; faults detected here skip straight to FIN
//   S_WAIT    | MOV high, waiting for MOC or the timeout
//   S_RELEASE | MOV low, waiting for MOC to drop before finishing
//   S_FIN     | done pulse cycle; busy, enable and error flags clear on exit
module mem_access_ctrl
    import mem_defs_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [5:0]        op3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              err_misaligned,
    output logic              err_illegal,
    output logic              err_timeout,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    output logic              mem_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_out,
    input  logic [31:0]       mem_data_in,
    input  logic              mem_moc
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    mem_state_t      state;
    logic [TO_W-1:0] tmo_cnt;

    logic [1:0] dec_size;
    logic       dec_sign;
    logic       dec_rw;
    logic       dec_illegal;
    logic       misaligned;

    mem_op_decode u_decode (
        .op3     (op3),
        .size    (dec_size),
        .sign    (dec_sign),
        .rw      (dec_rw),
        .illegal (dec_illegal)
    );

    assign misaligned = is_misaligned(dec_size, addr[1:0]);

    // Handshake FSM; every output is a register so the RAM sees clean levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            tmo_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            load_data      <= '0;
            err_misaligned <= 1'b0;
            err_illegal    <= 1'b0;
            err_timeout    <= 1'b0;
            mem_mov        <= 1'b0;
            mem_rw         <= 1'b0;
            mem_size       <= SZ_BYTE;
            mem_sign       <= 1'b0;
            mem_enable     <= 1'b0;
            mem_address    <= '0;
            mem_data_out   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (dec_illegal) begin
                            err_illegal <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_FIN;
                        end else if (misaligned) begin
                            err_misaligned <= 1'b1;
                            done           <= 1'b1;
                            state          <= S_FIN;
                        end else begin
                            mem_address  <= addr;
                            mem_size     <= dec_size;
                            mem_sign     <= dec_sign;
                            mem_rw       <= dec_rw;
                            mem_data_out <= store_data;
                            mem_enable   <= 1'b1;
                            mem_mov      <= 1'b1;
                            tmo_cnt      <= '0;
                            state        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_moc) begin
                        if (mem_rw)
                            load_data <= mem_data_in;
                        mem_mov <= 1'b0;
                        state   <= S_RELEASE;
                    end else if (tmo_cnt == TO_LAST) begin
                        // Leaving WAIT here is what keeps the counter from wrapping.
                        mem_mov     <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= S_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!mem_moc) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy           <= 1'b0;
                    mem_enable     <= 1'b0;
                    err_misaligned <= 1'b0;
                    err_illegal    <= 1'b0;
                    err_timeout    <= 1'b0;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a big-endian 512-byte RAM model answers MOV with
// a same-cycle MOC; expected results are queued at request time and popped
// when done pulses.
module tb_mem_access_ctrl;
    import mem_defs_pkg::*;

    logic        clk;
    logic        reset;
    logic        req;
    logic [5:0]  op3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err_misaligned;
    logic        err_illegal;
    logic        err_timeout;
    logic        mem_mov;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic        mem_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_moc;

    int errors = 0;
    int checks = 0;

    logic [34:0] exp_q[$];

    logic        moc_block;
    logic [7:0]  ram_mem [0:511];
    logic [8:0]  a0;
    logic [31:0] rd;

    logic [31:0] snap_addr;
    logic [31:0] snap_dout;
    logic [1:0]  snap_size;
    logic        snap_sign;
    logic        snap_rw;

    mem_access_ctrl #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .op3            (op3),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .err_misaligned (err_misaligned),
        .err_illegal    (err_illegal),
        .err_timeout    (err_timeout),
        .mem_mov        (mem_mov),
        .mem_rw         (mem_rw),
        .mem_size       (mem_size),
        .mem_sign       (mem_sign),
        .mem_enable     (mem_enable),
        .mem_address    (mem_address),
        .mem_data_out   (mem_data_out),
        .mem_data_in    (mem_data_in),
        .mem_moc        (mem_moc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: same-cycle MOC, big-endian byte lanes, preload under reset.
    assign mem_moc = mem_mov & mem_enable & ~moc_block;

    always_comb begin
        a0 = mem_address[8:0];
        rd = '0;
        case (mem_size)
            SZ_BYTE: rd = {{24{mem_sign & ram_mem[a0][7]}}, ram_mem[a0]};
            SZ_HALF: rd = {{16{mem_sign & ram_mem[a0][7]}}, ram_mem[a0], ram_mem[a0 + 9'd1]};
            default: rd = {ram_mem[a0], ram_mem[a0 + 9'd1], ram_mem[a0 + 9'd2], ram_mem[a0 + 9'd3]};
        endcase
    end
    assign mem_data_in = rd;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) ram_mem[i] <= 8'h00;
            ram_mem[4]  <= 8'h85;
            ram_mem[8]  <= 8'h11;
            ram_mem[9]  <= 8'h22;
            ram_mem[10] <= 8'h33;
            ram_mem[11] <= 8'h44;
        end else if (mem_mov && mem_enable && !mem_rw) begin
            case (mem_size)
                SZ_BYTE: ram_mem[a0] <= mem_data_out[7:0];
                SZ_HALF: begin
                    ram_mem[a0]        <= mem_data_out[15:8];
                    ram_mem[a0 + 9'd1] <= mem_data_out[7:0];
                end
                default: begin
                    ram_mem[a0]        <= mem_data_out[31:24];
                    ram_mem[a0 + 9'd1] <= mem_data_out[23:16];
                    ram_mem[a0 + 9'd2] <= mem_data_out[15:8];
                    ram_mem[a0 + 9'd3] <= mem_data_out[7:0];
                end
            endcase
        end
    end

    // One access: queue the expectation, pulse req, follow the handshake,
    // pop and compare on done, then check the cycle after done is quiet.
    task automatic run_access(input string name, input logic [5:0] o, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] exp_ld,
                              input logic [2:0] exp_err, input int exp_lat, input int exp_mov,
                              input bit hold_req);
        logic [34:0] exp;
        int lat;
        int mov_n;
        bit seen_done;
        exp_q.push_back({exp_ld, exp_err});
        snap_addr = '0; snap_dout = '0; snap_size = '0; snap_sign = 1'b0; snap_rw = 1'b0;
        @(negedge clk);
        op3 = o; addr = a; store_data = sd; req = 1'b1;
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        else begin addr = a ^ 32'h0000_0100; store_data = ~sd; op3 = OP_STB; end
        lat = 1; mov_n = 0; seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mem_mov) begin
                if (mov_n == 0) begin
                    snap_addr = mem_address; snap_dout = mem_data_out;
                    snap_size = mem_size; snap_sign = mem_sign; snap_rw = mem_rw;
                end else begin
                    checks++;
                    if ({mem_address, mem_data_out, mem_size, mem_sign, mem_rw, mem_enable} !==
                        {snap_addr, snap_dout, snap_size, snap_sign, snap_rw, 1'b1}) begin
                        errors++;
                        $display("FAIL %s stable: addr=%h dout=%h required addr=%h dout=%h",
                                 name, mem_address, mem_data_out, snap_addr, snap_dout);
                    end
                end
                mov_n++;
            end
            if (done) begin seen_done = 1'b1; break; end
            @(negedge clk);
            lat++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s done: no done pulse within 40 cycles", name);
        end else begin
            checks++;
            if (load_data !== exp[34:3]) begin
                errors++;
                $display("FAIL %s load_data: got %h required %h", name, load_data, exp[34:3]);
            end
            checks++;
            if ({err_illegal, err_misaligned, err_timeout} !== exp[2:0]) begin
                errors++;
                $display("FAIL %s err(ill,mis,tmo): got %b required %b", name,
                         {err_illegal, err_misaligned, err_timeout}, exp[2:0]);
            end
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
            end
            checks++;
            if (mov_n !== exp_mov) begin
                errors++;
                $display("FAIL %s mov cycles: got %0d required %0d", name, mov_n, exp_mov);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, err_illegal, err_misaligned, err_timeout, mem_enable, mem_mov} !== 7'b0) begin
            errors++;
            $display("FAIL %s after done: done=%b busy=%b err=%b%b%b en=%b mov=%b required all 0",
                     name, done, busy, err_illegal, err_misaligned, err_timeout, mem_enable, mem_mov);
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; op3 = '0; addr = '0; store_data = '0; moc_block = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err_misaligned, err_illegal, err_timeout, mem_mov, mem_rw,
             mem_sign, mem_enable, mem_size} !== 11'b0) begin
            errors++;
            $display("FAIL reset ctrl: busy=%b done=%b mov=%b en=%b rw=%b required 0",
                     busy, done, mem_mov, mem_enable, mem_rw);
        end
        checks++;
        if ({load_data, mem_address, mem_data_out} !== 96'b0) begin
            errors++;
            $display("FAIL reset data: ld=%h addr=%h dout=%h required 0",
                     load_data, mem_address, mem_data_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        run_access("ldub", OP_LDUB, 32'h004, 32'h0, 32'h0000_0085, 3'b000, 3, 1, 1'b0);
        checks++;
        if ({snap_addr, snap_size, snap_sign, snap_rw} !== {32'h004, SZ_BYTE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ldub ctrl: addr=%h size=%b sign=%b rw=%b required 004 00 0 1",
                     snap_addr, snap_size, snap_sign, snap_rw);
        end
        run_access("ldsb", OP_LDSB, 32'h004, 32'h0, 32'hFFFF_FF85, 3'b000, 3, 1, 1'b0);
        checks++;
        if (snap_sign !== 1'b1) begin
            errors++;
            $display("FAIL ldsb sign: got %b required 1", snap_sign);
        end
        run_access("ld", OP_LD, 32'h008, 32'h0, 32'h1122_3344, 3'b000, 3, 1, 1'b0);
        checks++;
        if (snap_size !== SZ_WORD) begin
            errors++;
            $display("FAIL ld size: got %b required 10", snap_size);
        end
    endtask

    task automatic test_store_load();
        run_access("sth", OP_STH, 32'h010, 32'h0000_BEEF, 32'h1122_3344, 3'b000, 3, 1, 1'b0);
        checks++;
        if ({snap_rw, snap_size, snap_dout} !== {1'b0, SZ_HALF, 32'h0000_BEEF}) begin
            errors++;
            $display("FAIL sth ctrl: rw=%b size=%b dout=%h required 0 01 0000beef",
                     snap_rw, snap_size, snap_dout);
        end
        run_access("lduh", OP_LDUH, 32'h010, 32'h0, 32'h0000_BEEF, 3'b000, 3, 1, 1'b0);
        run_access("ldsh", OP_LDSH, 32'h010, 32'h0, 32'hFFFF_BEEF, 3'b000, 3, 1, 1'b0);
        run_access("stb", OP_STB, 32'h020, 32'hDEAD_BEA5, 32'hFFFF_BEEF, 3'b000, 3, 1, 1'b0);
        checks++;
        if (snap_dout !== 32'hDEAD_BEA5) begin
            errors++;
            $display("FAIL stb dout: got %h required deadbea5", snap_dout);
        end
        run_access("ldsb2", OP_LDSB, 32'h020, 32'h0, 32'hFFFF_FFA5, 3'b000, 3, 1, 1'b0);
        run_access("st", OP_ST, 32'h024, 32'hCAFE_F00D, 32'hFFFF_FFA5, 3'b000, 3, 1, 1'b0);
        run_access("ld2", OP_LD, 32'h024, 32'h0, 32'hCAFE_F00D, 3'b000, 3, 1, 1'b0);
    endtask

    task automatic test_faults();
        run_access("ld_mis", OP_LD, 32'h006, 32'h0, 32'hCAFE_F00D, 3'b010, 1, 0, 1'b0);
        run_access("illegal", 6'b111111, 32'h000, 32'h0, 32'hCAFE_F00D, 3'b100, 1, 0, 1'b0);
        run_access("ill_prio", 6'b111111, 32'h003, 32'h0, 32'hCAFE_F00D, 3'b100, 1, 0, 1'b0);
        run_access("lduh_mis", OP_LDUH, 32'h011, 32'h0, 32'hCAFE_F00D, 3'b010, 1, 0, 1'b0);
        run_access("ldub_odd", OP_LDUB, 32'h003, 32'h0, 32'h0000_0000, 3'b000, 3, 1, 1'b0);
    endtask

    task automatic test_timeout();
        moc_block = 1'b1;
        run_access("timeout", OP_LD, 32'h008, 32'h0, 32'h0000_0000, 3'b001, 18, 16, 1'b0);
        moc_block = 1'b0;
    endtask

    task automatic test_reset_mid();
        moc_block = 1'b1;
        @(negedge clk);
        op3 = OP_LD; addr = 32'h008; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_mov, busy} !== 2'b11) begin
            errors++;
            $display("FAIL mid wait: mov=%b busy=%b required 1 1", mem_mov, busy);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_mov, busy, mem_enable, done} !== 4'b0) begin
            errors++;
            $display("FAIL mid async reset: mov=%b busy=%b en=%b done=%b required 0",
                     mem_mov, busy, mem_enable, done);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        moc_block = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL mid no done: done=%b required 0", done);
            end
            @(negedge clk);
        end
        run_access("ld_after_rst", OP_LD, 32'h008, 32'h0, 32'h1122_3344, 3'b000, 3, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_access("ld_held", OP_LD, 32'h008, 32'h0, 32'h1122_3344, 3'b000, 3, 1, 1'b1);
        checks++;
        if (snap_addr !== 32'h008) begin
            errors++;
            $display("FAIL held addr: got %h required 00000008", snap_addr);
        end
        run_access("ldub_next", OP_LDUB, 32'h004, 32'h0, 32'h0000_0085, 3'b000, 3, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_load();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the RAM MOV/MOC handshake. Accepts one load/store request from the control unit and decodes the SPARC op3 field into the RAM's size, sign and RW inputs.
- Checks address alignment, drives MOV, and waits for MOC. Returns load data, or a fault flag, with a single-cycle done pulse.
- Sits between the CPU control unit/datapath and the ram module.

Parameters:
- TIMEOUT_CYCLES, 16: number of WAIT cycles without MOC before the access is aborted with a timeout error.
- ADDR_W, 32: address width. ram uses only bits [8:0]; the full word is passed through.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  start request; sampled only in IDLE
- op3  in  6  load/store opcode
- addr  in  ADDR_W  byte address
- store_data  in  32  data for stores
- busy  out  1  high from request acceptance until done
- done  out  1  one-cycle completion pulse
- load_data  out  32  captured RAM read data; holds until the next load completes
- err_misaligned  out  1  valid with done
- err_illegal  out  1  valid with done
- err_timeout  out  1  valid with done
- mem_mov  out  1  to ram MOV
- mem_rw  out  1  to ram RW; 1 = read, 0 = write
- mem_size  out  2  to ram size; 00 = byte, 01 = half, 10 = word
- mem_sign  out  1  to ram sign
- mem_enable  out  1  to ram enable
- mem_address  out  ADDR_W  to ram address
- mem_data_out  out  32  to ram dataIn
- mem_data_in  in  32  from ram dataOut
- mem_moc  in  1  from ram MOC

Behaviour:
- Reset: clk is the single clock; reset is asynchronous and active-high.
  - All outputs go to 0 immediately: busy, done, load_data, the err_* flags, and every mem_* signal. State goes to IDLE.
  - Reset mid-access drops mem_mov at once and discards the access. No done pulse is issued.
- All outputs are registered. mem_moc and mem_data_in are sampled only on the rising edge of clk.
- op3 decode:
  - LDSB 001001: size 00, sign 1, rw 1
  - LDSH 001010: size 01, sign 1, rw 1
  - LDUB 000001: size 00, sign 0, rw 1
  - LDUH 000010: size 01, sign 0, rw 1
  - LD 000000: size 10, sign 0, rw 1
  - STB 000101: size 00, rw 0
  - STH 000110: size 01, rw 0
  - ST 000100: size 10, rw 0
  - Any other op3 is illegal.
- Alignment: a halfword access requires addr[0]=0. A word access requires addr[1:0]=00. Byte accesses are always aligned.
- Error priority: illegal, then misaligned, then timeout. Exactly one err_* flag is high with any faulting done.
- FSM states: IDLE, WAIT, RELEASE, FIN.
  - IDLE, req=1, illegal op3: go to FIN; latch err_illegal; mem_mov stays 0.
  - IDLE, req=1, misaligned: go to FIN; latch err_misaligned; mem_mov stays 0.
  - IDLE, req=1, valid: latch mem_address, mem_size, mem_sign, mem_rw and mem_data_out (= store_data). Set mem_enable=1, mem_mov=1, busy=1. Go to WAIT.
  - WAIT, mem_moc=1: if rw=1, load_data <= mem_data_in. Then mem_mov <= 0 and go to RELEASE.
  - WAIT, no mem_moc for TIMEOUT_CYCLES consecutive edges: mem_mov <= 0, latch err_timeout, go to RELEASE.
  - RELEASE: hold mem_mov=0 and wait for mem_moc=0. When it is 0, go to FIN.
  - FIN: done=1 for exactly one cycle. Clear busy and mem_enable. Go to IDLE. The err_* flags clear on the following cycle.
- Latency, with a RAM that responds in the same cycle:
  - req accepted at edge 0, MOC sampled at edge 1, RELEASE exits at edge 2, done is high during cycle 2-3.
  - Fault path: done is high during cycle 1-2.
- Handshake rules:
  - mem_address, mem_size, mem_sign, mem_rw and mem_data_out are stable for the whole time mem_mov=1.
  - mem_mov always returns to 0 for at least one cycle between accesses.
  - A MOC still high from the previous access is never counted, because RELEASE waits for it to drop.
- req is ignored whenever busy=1, including a req that coincides with the done cycle. A new req is first accepted in the cycle after done.
- The timeout counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide, cleared on entry to WAIT, and saturates.
- The store path does not modify data. ram selects the low bytes of dataIn according to size.

Decomposition:
- Shared package mem_defs_pkg holds:
  - op3 localparams (OP_LDSB, OP_LDSH, OP_LDUB, OP_LDUH, OP_LD, OP_STB, OP_STH, OP_ST)
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - FSM state encoding
- One combinational sub-module, mem_op_decode: op3 in; size, sign, rw and illegal out. It is reusable by the control unit.

Test Plan:
- LDUB, addr=0x004, RAM byte 0x85: mem_mov rises after the accept edge with size=00, sign=0, rw=1. load_data=0x00000085, done after 3 edges, no err.
- LDSB with the same byte: mem_sign=1, load_data=0xFFFFFF85. LD at 0x008 with bytes 11 22 33 44: load_data=0x11223344.
- STH at 0x010, store_data=0x0000BEEF, then LDUH at 0x010: mem_rw=0 during the store, mem_data_out=0x0000BEEF. The read returns 0x0000BEEF.
- LD at addr=0x006: no mem_mov pulse, done with err_misaligned=1 one cycle after req. op3=111111: done with err_illegal=1.
- mem_moc held at 0 by the bench: mem_mov drops after 16 WAIT cycles, then done with err_timeout=1 and load_data unchanged.
- Assert reset in WAIT: mem_mov and busy go to 0 with no clock edge needed, and no done pulse. A subsequent LD completes normally. A req held high during busy is ignored.
